// File: rtl/spot_centroid_tracker.sv
// Bright-spot centroid engine: gates pixels by window and per-channel threshold,
// accumulates count and coordinate sums per frame, then divides once per frame.
module spot_centroid_tracker #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned X_W        = 11,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PIXELS = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_CH*CH_W-1:0] pixel_in,
  input  logic                   pixel_valid_in,
  input  logic [X_W-1:0]         x_in,
  input  logic [Y_W-1:0]         y_in,
  input  logic                   frame_done_in,
  input  logic [CH_W-1:0]        thresh_in,
  input  logic                   mode_any_in,
  input  logic [X_W-1:0]         x_min_in,
  input  logic [X_W-1:0]         x_max_in,
  input  logic [Y_W-1:0]         y_min_in,
  input  logic [Y_W-1:0]         y_max_in,
  output logic [X_W-1:0]         centroid_x_out,
  output logic [Y_W-1:0]         centroid_y_out,
  output logic [CNT_W-1:0]       count_out,
  output logic                   found_out,
  output logic                   saturated_out,
  output logic                   result_valid_out,
  output logic                   busy_out,
  output logic                   overrun_out
);

  localparam int unsigned PIX_W = NUM_CH * CH_W;
  localparam int unsigned SX_W  = X_W + CNT_W;
  localparam int unsigned SY_W  = Y_W + CNT_W;
  localparam int unsigned DW    = SX_W;
  localparam int unsigned IT_W  = $clog2(DW + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  // Pixel qualification: window bounds and per-channel threshold
  logic any_hit_c, all_hit_c, in_win_c, qual_c;

  always_comb begin
    any_hit_c = 1'b0;
    all_hit_c = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pixel_in[PIX_W - CH_W*(i+1) +: CH_W] > thresh_in) any_hit_c = 1'b1;
      else                                                  all_hit_c = 1'b0;
    end
  end

  // An inverted window (min > max) admits no coordinate, so no extra term is needed
  assign in_win_c = (x_in >= x_min_in) && (x_in <= x_max_in) &&
                    (y_in >= y_min_in) && (y_in <= y_max_in);
  assign qual_c   = pixel_valid_in && in_win_c && (mode_any_in ? any_hit_c : all_hit_c);

  // Frame accumulators; *_acc includes this cycle's pixel and is the snapshot source
  logic [CNT_W-1:0] cnt_q, cnt_acc, cnt_d;
  logic [SX_W-1:0]  sum_x_q, sum_x_acc, sum_x_d;
  logic [SY_W-1:0]  sum_y_q, sum_y_acc, sum_y_d;
  logic             sat_q, sat_acc, sat_d;
  logic             cnt_full_c, take_c;

  assign cnt_full_c = (cnt_q == '1);
  assign take_c     = qual_c && !cnt_full_c;
  assign cnt_acc    = take_c ? cnt_q + CNT_W'(1)     : cnt_q;
  assign sum_x_acc  = take_c ? sum_x_q + SX_W'(x_in) : sum_x_q;
  assign sum_y_acc  = take_c ? sum_y_q + SY_W'(y_in) : sum_y_q;
  assign sat_acc    = sat_q | (qual_c & cnt_full_c);

  assign cnt_d   = frame_done_in ? '0   : cnt_acc;
  assign sum_x_d = frame_done_in ? '0   : sum_x_acc;
  assign sum_y_d = frame_done_in ? '0   : sum_y_acc;
  assign sat_d   = frame_done_in ? 1'b0 : sat_acc;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      sat_q   <= sat_d;
    end
  end

  // Restoring divider step; the dividend register shifts quotient bits in from the LSB
  state_e           state_q;
  logic [CNT_W-1:0] divisor_q, x_rem_q, y_rem_q, snap_cnt_q;
  logic [DW-1:0]    x_div_q, y_div_q;
  logic [IT_W-1:0]  iter_q;
  logic             snap_sat_q;
  logic [CNT_W:0]   x_trial_c, y_trial_c;
  logic             x_ge_c, y_ge_c;
  logic [CNT_W-1:0] x_rem_step_c, y_rem_step_c;

  assign x_trial_c    = {x_rem_q, x_div_q[DW-1]};
  assign y_trial_c    = {y_rem_q, y_div_q[DW-1]};
  assign x_ge_c       = (x_trial_c >= {1'b0, divisor_q});
  assign y_ge_c       = (y_trial_c >= {1'b0, divisor_q});
  assign x_rem_step_c = x_ge_c ? CNT_W'(x_trial_c - {1'b0, divisor_q}) : x_trial_c[CNT_W-1:0];
  assign y_rem_step_c = y_ge_c ? CNT_W'(y_trial_c - {1'b0, divisor_q}) : y_trial_c[CNT_W-1:0];

  logic [X_W-1:0]   centroid_x_q;
  logic [Y_W-1:0]   centroid_y_q;
  logic [CNT_W-1:0] count_q;
  logic             found_q, saturated_q, result_valid_q, busy_q, overrun_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      divisor_q      <= '0;
      x_rem_q        <= '0;
      y_rem_q        <= '0;
      x_div_q        <= '0;
      y_div_q        <= '0;
      iter_q         <= '0;
      snap_cnt_q     <= '0;
      snap_sat_q     <= 1'b0;
      centroid_x_q   <= '0;
      centroid_y_q   <= '0;
      count_q        <= '0;
      found_q        <= 1'b0;
      saturated_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (frame_done_in && (state_q != S_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (frame_done_in) begin
            divisor_q  <= cnt_acc;
            x_div_q    <= sum_x_acc;
            y_div_q    <= DW'(sum_y_acc);
            x_rem_q    <= '0;
            y_rem_q    <= '0;
            iter_q     <= '0;
            snap_cnt_q <= cnt_acc;
            snap_sat_q <= sat_acc;
            // An empty frame has zero sums, so the quotient registers already hold 0
            busy_q     <= (cnt_acc != '0);
            state_q    <= (cnt_acc == '0) ? S_DONE : S_DIV;
          end
        end
        S_DIV: begin
          x_rem_q <= x_rem_step_c;
          y_rem_q <= y_rem_step_c;
          x_div_q <= {x_div_q[DW-2:0], x_ge_c};
          y_div_q <= {y_div_q[DW-2:0], y_ge_c};
          iter_q  <= iter_q + IT_W'(1);
          if (iter_q == IT_W'(DW - 1)) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          centroid_x_q   <= x_div_q[X_W-1:0];
          centroid_y_q   <= y_div_q[Y_W-1:0];
          count_q        <= snap_cnt_q;
          found_q        <= (snap_cnt_q >= CNT_W'(MIN_PIXELS));
          saturated_q    <= snap_sat_q;
          result_valid_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign centroid_x_out   = centroid_x_q;
  assign centroid_y_out   = centroid_y_q;
  assign count_out        = count_q;
  assign found_out        = found_q;
  assign saturated_out    = saturated_q;
  assign result_valid_out = result_valid_q;
  assign busy_out         = busy_q;
  assign overrun_out      = overrun_q;

endmodule
